palette_rgb_decoder: RTL and testbench

- Parametrised successor of the 3-bit colour-code-to-RGB decoder in the VGA text path.
- Maps a per-pixel colour index to an RGB word through a run-time-writable palette.
- Adds a registered output stage, blank forcing, and a frame-counted blink attribute.
- Sits between the character/glyph renderer and the VGA DAC/RGB output pins.

---
 rtl/palette_rgb_decoder.sv | 121 ++++++++++++
 tb/tb_palette_rgb_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_rgb_decoder.sv
// Palette-based colour-index to RGB decoder for the VGA text path.
// Registered single-cycle pixel path with blank forcing, frame-counted blink
// and a run-time writable palette with write-first bypass.
// Optional macro PALETTE_RDBACK_EN adds a palette readback port.
module palette_rgb_decoder #(
  parameter int unsigned         IDX_W        = 3,
  parameter int unsigned         CH_W         = 8,
  parameter logic [3*CH_W-1:0]   DEFAULT_FG   = 24'h111111,
  parameter int unsigned         BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid_i,
  input  logic [IDX_W-1:0]     pix_idx_i,
  input  logic                 pix_blink_i,
  input  logic                 blank_i,
  input  logic                 frame_start_i,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_addr_i,
  input  logic [3*CH_W-1:0]    wr_data_i,
  output logic [3*CH_W-1:0]    rgb_o,
  output logic                 rgb_valid_o,
`ifdef PALETTE_RDBACK_EN
  input  logic [IDX_W-1:0]     rd_addr_i,
  output logic [3*CH_W-1:0]    rd_data_o,
`endif
  output logic                 blink_phase_o
);

  localparam int unsigned RGB_W = 3 * CH_W;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [RGB_W-1:0] r_pal [DEPTH];
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic [RGB_W-1:0] r_rgb;
  logic             r_rgb_valid;

  logic [IDX_W-1:0] w_pix_addr;
  logic [RGB_W-1:0] w_pix_data;

  assign rgb_o         = r_rgb;
  assign rgb_valid_o   = r_rgb_valid;
  assign blink_phase_o = r_blink_phase;

  // Palette storage: reset to black with the top entry as default foreground.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pal[i] <= (i == DEPTH - 1) ? DEFAULT_FG : '0;
      end
    end else if (wr_en_i) begin
      r_pal[wr_addr_i] <= wr_data_i;
    end
  end

  // Pixel lookup: hidden blink pixels read the background entry; same-cycle write wins.
  always_comb begin
    w_pix_addr = pix_idx_i;
    if (pix_blink_i && !r_blink_phase) begin
      w_pix_addr = '0;
    end
    w_pix_data = r_pal[w_pix_addr];
    if (wr_en_i && (wr_addr_i == w_pix_addr)) begin
      w_pix_data = wr_data_i;
    end
  end

  // Blink counter: phase flips after BLINK_FRAMES frame pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (frame_start_i) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Output register: invalid and blanked pixels are forced black.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else if (!pix_valid_i) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else if (blank_i) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b1;
    end else begin
      r_rgb       <= w_pix_data;
      r_rgb_valid <= 1'b1;
    end
  end

`ifdef PALETTE_RDBACK_EN
  logic [RGB_W-1:0] r_rd_data;
  assign rd_data_o = r_rd_data;

  // Readback port: independent of the pixel path, same write-first bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      r_rd_data <= wr_data_i;
    end else begin
      r_rd_data <= r_pal[rd_addr_i];
    end
  end
`else
  // Readback port not built.
`endif

endmodule

// File: tb/tb_palette_rgb_decoder.sv
// Self-checking bench for palette_rgb_decoder (BLINK_FRAMES=2).
module tb_palette_rgb_decoder;

  localparam int unsigned BF = 2;

  logic        clk;
  logic        rst_n;
  logic        pix_valid_i;
  logic [2:0]  pix_idx_i;
  logic        pix_blink_i;
  logic        blank_i;
  logic        frame_start_i;
  logic        wr_en_i;
  logic [2:0]  wr_addr_i;
  logic [23:0] wr_data_i;
  logic [23:0] rgb_o;
  logic        rgb_valid_o;
  logic        blink_phase_o;

  palette_rgb_decoder #(
    .IDX_W(3), .CH_W(8), .DEFAULT_FG(24'h111111), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid_i(pix_valid_i), .pix_idx_i(pix_idx_i), .pix_blink_i(pix_blink_i),
    .blank_i(blank_i), .frame_start_i(frame_start_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rgb_o(rgb_o), .rgb_valid_o(rgb_valid_o), .blink_phase_o(blink_phase_o)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        v;
    logic        ph;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [23:0] m_pal [8];
  logic        m_phase;
  int          m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pal[i] = 24'h0;
    m_pal[7] = 24'h111111;
    m_phase  = 1'b1;
    m_cnt    = 0;
  endtask

  // Drive one cycle, push the expected result, advance the model, step past the edge.
  task automatic drive(input logic v, input logic [2:0] idx, input logic bl,
                       input logic bk, input logic fs, input logic we,
                       input logic [2:0] wa, input logic [23:0] wd);
    exp_t       x;
    logic [2:0] a;
    pix_valid_i = v; pix_idx_i = idx; pix_blink_i = bl; blank_i = bk;
    frame_start_i = fs; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    if (!v) begin
      x.rgb = 24'h0; x.v = 1'b0;
    end else if (bk) begin
      x.rgb = 24'h0; x.v = 1'b1;
    end else begin
      a = (bl && !m_phase) ? 3'd0 : idx;
      x.rgb = (we && (wa == a)) ? wd : m_pal[a];
      x.v = 1'b1;
    end
    if (we) m_pal[wa] = wd;
    if (fs) begin
      if (m_cnt == int'(BF) - 1) begin
        m_cnt = 0; m_phase = ~m_phase;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    x.ph = m_phase;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (rgb_o !== 24'h0 || rgb_valid_o !== 1'b0 || blink_phase_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: rgb=%h valid=%b phase=%b expected rgb=000000 valid=0 phase=1",
               rgb_o, rgb_valid_o, blink_phase_o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        1:       drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        default: drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
      endcase
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL reset_defaults step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 24'hFF8000);
        1:       drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        default: drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 24'hABCDEF);
      endcase
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL write_read step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 24'h00FF00);
        1:       drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        default: drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 24'h0000FF);
      endcase
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL collision step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
  endtask

  task automatic test_blank_valid();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h0);
        1:       drive(1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h0);
        default: drive(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
      endcase
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL blank_valid step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
  endtask

  task automatic test_blink();
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 1, 4, 5: drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 24'h0);
        2, 6:       drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        3, 7:       drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        default:    drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
      endcase
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL blink step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 24'($urandom));
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 24'h123456);
        1:       drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        default: drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 24'h0);
      endcase
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL reset_mid_pre step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
    // Reset cycle with a concurrent write and pixel: reset must win.
    rst_n = 1'b0;
    pix_valid_i = 1'b1; pix_idx_i = 3'd0; pix_blink_i = 1'b0; blank_i = 1'b0;
    frame_start_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = 24'hABCDEF;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    n_checks++;
    if (rgb_o !== 24'h0 || rgb_valid_o !== 1'b0 || blink_phase_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_state: rgb=%h valid=%b phase=%b expected rgb=000000 valid=0 phase=1",
               rgb_o, rgb_valid_o, blink_phase_o);
    end
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        1:       drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
        2, 3:    drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 24'h0);
        default: drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
      endcase
      e = q.pop_front(); n_checks++;
      if (rgb_o !== e.rgb || rgb_valid_o !== e.v || blink_phase_o !== e.ph) begin
        n_fail++;
        $display("FAIL reset_mid_post step %0d: rgb=%h valid=%b phase=%b expected rgb=%h valid=%b phase=%b",
                 i, rgb_o, rgb_valid_o, blink_phase_o, e.rgb, e.v, e.ph);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pix_valid_i = 1'b0; pix_idx_i = 3'd0; pix_blink_i = 1'b0; blank_i = 1'b0;
    frame_start_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = 3'd0; wr_data_i = 24'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_collision();
    test_blank_valid();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
